// File: rtl/sched_pkg.sv
// Shared definitions for the schedule executor: word field layout, opcodes,
// FSM state names and the schedule-word validity check.
package sched_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_BANKS = 8;
    localparam int unsigned BANK_W    = 3;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned ROW_W     = 8;

    // Schedule word field positions
    localparam int unsigned RSVD_HI_MSB = 31;
    localparam int unsigned RSVD_HI_LSB = 24;
    localparam int unsigned MASK_MSB    = 23;
    localparam int unsigned MASK_LSB    = 16;
    localparam int unsigned OP_MSB      = 15;
    localparam int unsigned OP_LSB      = 12;
    localparam int unsigned RSVD_LO_MSB = 11;
    localparam int unsigned RSVD_LO_LSB = 8;
    localparam int unsigned ROW_MSB     = 7;
    localparam int unsigned ROW_LSB     = 0;

    localparam logic [OP_W-1:0] OP_REFRESH = 4'h3;
    localparam logic [OP_W-1:0] OP_WRITE   = 4'h5;
    localparam logic [OP_W-1:0] OP_READ    = 4'hA;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } sched_state_e;

    // A word is well-formed when both reserved fields are zero and the opcode is known
    function automatic logic sched_word_valid(input logic [WORD_W-1:0] w);
        logic [OP_W-1:0] op;
        logic            rsvd_clear;
        op         = w[OP_MSB:OP_LSB];
        rsvd_clear = (w[RSVD_HI_MSB:RSVD_HI_LSB] == '0) && (w[RSVD_LO_MSB:RSVD_LO_LSB] == '0);
        return rsvd_clear && ((op == OP_REFRESH) || (op == OP_WRITE) || (op == OP_READ));
    endfunction

endpackage

// File: rtl/sched_fifo.sv
// Synchronous FIFO with first-word fall-through read data; writes when full
// and reads when empty are ignored.
module sched_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_fire_c;
    logic             rd_fire_c;

    assign full_c    = (count == CW'(DEPTH));
    assign empty_c   = (count == '0);
    assign wr_fire_c = wr_en && !full_c;
    assign rd_fire_c = rd_en && !empty_c;
    assign rd_data_c = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire_c) wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire_c) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_fire_c) - CW'(rd_fire_c);
        end
    end

endmodule

// File: rtl/schedule_executor.sv
// Schedule link receiver: captures schedule words, buffers them, and expands
// each into one memory command per enabled bank.
// Optional: SCHED_EXEC_ERR_CNT_EN adds a saturating 8-bit err_count output.
module schedule_executor
    import sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx,
    input  logic [WORD_W-1:0] schedule_in,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic [BANK_W-1:0] mem_bank,
    output logic [OP_W-1:0]   mem_op,
    output logic [ROW_W-1:0]  mem_row,
    output logic              sched_done,
    output logic              sched_err,
    output logic              busy
`ifdef SCHED_EXEC_ERR_CNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_ISSUE = 2'(ISSUE);
    localparam logic [1:0] ST_DONE  = 2'(DONE);

    logic                 prev_tx;
    logic [WORD_W-1:0]    last_word;
    logic                 capture_c;
    logic                 word_ok_c;
    logic                 wr_fire_c;
    logic                 err_n;

    logic [WORD_W-1:0]    fifo_rd_data_c;
    logic                 fifo_full_c;
    logic                 fifo_empty_c;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W-1:0]     fifo_count_n;
    logic                 pop_c;

    logic [1:0]           state;
    logic [1:0]           state_n;
    logic [NUM_BANKS-1:0] mask;
    logic [NUM_BANKS-1:0] mask_n;
    logic [NUM_BANKS-1:0] mask_clr_c;
    logic [BANK_W-1:0]    low_bank_c;
    logic                 fire_c;
    logic                 valid_n;
    logic [BANK_W-1:0]    bank_n;
    logic [OP_W-1:0]      op_n;
    logic [ROW_W-1:0]     row_n;
    logic                 done_n;
    logic                 busy_n;
    logic                 unused_rsvd_c;

    // New word on a rising tx level or when the held word changes
    assign capture_c = tx && (!prev_tx || (schedule_in != last_word));
    assign word_ok_c = sched_word_valid(schedule_in);
    assign wr_fire_c = capture_c && word_ok_c && !fifo_full_c;
    assign err_n     = capture_c && (!word_ok_c || fifo_full_c);

    assign fifo_count_n  = fifo_count + CNT_W'(wr_fire_c) - CNT_W'(pop_c);
    assign unused_rsvd_c = ^{fifo_rd_data_c[RSVD_HI_MSB:RSVD_HI_LSB],
                             fifo_rd_data_c[RSVD_LO_MSB:RSVD_LO_LSB]};

    sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (capture_c && word_ok_c),
        .wr_data   (schedule_in),
        .rd_en     (pop_c),
        .rd_data_c (fifo_rd_data_c),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c),
        .count     (fifo_count)
    );

    // Remaining mask once the current command's handshake is accounted for
    always_comb begin
        fire_c     = mem_cmd_valid && mem_cmd_ready;
        mask_clr_c = mask;
        if (fire_c) begin
            mask_clr_c = mask & ~(NUM_BANKS'(1) << mem_bank);
        end
    end

    // Lowest set bit of the remaining mask
    always_comb begin
        low_bank_c = '0;
        for (int i = int'(NUM_BANKS) - 1; i >= 0; i--) begin
            if (mask_clr_c[i]) low_bank_c = BANK_W'(i);
        end
    end

    // Next-state and output logic for word expansion
    always_comb begin
        state_n = state;
        mask_n  = mask;
        valid_n = mem_cmd_valid;
        bank_n  = mem_bank;
        op_n    = mem_op;
        row_n   = mem_row;
        done_n  = 1'b0;
        pop_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty_c) begin
                    pop_c   = 1'b1;
                    mask_n  = fifo_rd_data_c[MASK_MSB:MASK_LSB];
                    op_n    = fifo_rd_data_c[OP_MSB:OP_LSB];
                    row_n   = fifo_rd_data_c[ROW_MSB:ROW_LSB];
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mask_n = mask_clr_c;
                if (!mem_cmd_valid || fire_c) begin
                    if (mask_clr_c == '0) begin
                        valid_n = 1'b0;
                        done_n  = 1'b1;
                        state_n = ST_DONE;
                    end else begin
                        valid_n = 1'b1;
                        bank_n  = low_bank_c;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        busy_n = (state_n != ST_IDLE) || (fifo_count_n != '0);
    end

    // Capture history
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_tx   <= 1'b0;
            last_word <= '0;
        end else begin
            prev_tx <= tx;
            if (capture_c) last_word <= schedule_in;
        end
    end

    // FSM state, working mask and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            mask          <= '0;
            mem_cmd_valid <= 1'b0;
            mem_bank      <= '0;
            mem_op        <= '0;
            mem_row       <= '0;
            sched_done    <= 1'b0;
            sched_err     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            mask          <= mask_n;
            mem_cmd_valid <= valid_n;
            mem_bank      <= bank_n;
            mem_op        <= op_n;
            mem_row       <= row_n;
            sched_done    <= done_n;
            sched_err     <= err_n;
            busy          <= busy_n;
        end
    end

`ifdef SCHED_EXEC_ERR_CNT_EN
    // Saturating count of rejected words
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_n && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_schedule_executor.sv
// Testbench for schedule_executor: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_schedule_executor;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx = 1'b0;
    logic [31:0] schedule_in = '0;
    logic        mem_cmd_ready = 1'b0;
    logic        mem_cmd_valid;
    logic [2:0]  mem_bank;
    logic [3:0]  mem_op;
    logic [7:0]  mem_row;
    logic        sched_done;
    logic        sched_err;
    logic        busy;
`ifdef SCHED_EXEC_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    always #5 clk = ~clk;

    schedule_executor #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .tx            (tx),
        .schedule_in   (schedule_in),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_bank      (mem_bank),
        .mem_op        (mem_op),
        .mem_row       (mem_row),
        .sched_done    (sched_done),
        .sched_err     (sched_err),
        .busy          (busy)
`ifdef SCHED_EXEC_ERR_CNT_EN
        ,
        .err_count     (err_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending words, bank list of the word in service
    logic [31:0] m_q[$];
    int          m_banks[$];
    int          m_phase;      // 0 waiting for a word, 1 issuing, 2 reporting completion
    bit          m_prev_tx;
    logic [31:0] m_last;
    bit          m_valid, m_done, m_err;
    int          m_bank, m_op, m_row, m_errcnt;

    // Observation bookkeeping per scenario
    int obs[$];
    int exp_q[$];
    int seg_done, seg_err, edge_n, first_valid_edge, cap_edge;

    function automatic bit word_ok(input logic [31:0] w);
        int op;
        op = int'((w >> 12) & 32'hF);
        return ((w >> 24) == 0) && (((w >> 8) & 32'hF) == 0) && (op == 3 || op == 5 || op == 10);
    endfunction

    task automatic model_edge();
        bit cap, ok, was_full;
        logic [31:0] w;
        if (rst) begin
            m_q.delete(); m_banks.delete();
            m_phase = 0; m_prev_tx = 0; m_last = '0;
            m_valid = 0; m_done = 0; m_err = 0;
            m_bank = 0; m_op = 0; m_row = 0; m_errcnt = 0;
            return;
        end
        cap      = tx && (!m_prev_tx || schedule_in != m_last);
        ok       = word_ok(schedule_in);
        was_full = (m_q.size() == DEPTH);
        m_err    = cap && (!ok || was_full);
        if (m_err && m_errcnt < 255) m_errcnt++;
        m_done = 0;
        if (m_phase == 0) begin
            if (m_q.size() > 0) begin
                w = m_q.pop_front();
                m_banks.delete();
                for (int i = 0; i < 8; i++) if (((w >> (16 + i)) & 1) != 0) m_banks.push_back(i);
                m_op = int'((w >> 12) & 32'hF);
                m_row = int'(w & 32'hFF);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (m_valid && mem_cmd_ready) void'(m_banks.pop_front());
            if (!m_valid || mem_cmd_ready) begin
                if (m_banks.size() == 0) begin
                    m_valid = 0; m_done = 1; m_phase = 2;
                end else begin
                    m_valid = 1; m_bank = m_banks[0];
                end
            end
        end else begin
            m_phase = 0;
        end
        if (cap) m_last = schedule_in;
        if (cap && ok && !was_full) m_q.push_back(schedule_in);
        m_prev_tx = tx;
    endtask

    task automatic compare();
        check("valid", 32'(mem_cmd_valid), 32'(m_valid));
        if (m_valid) begin
            check("bank", 32'(mem_bank), 32'(m_bank));
            check("op",   32'(mem_op),   32'(m_op));
            check("row",  32'(mem_row),  32'(m_row));
        end
        check("done", 32'(sched_done), 32'(m_done));
        check("err",  32'(sched_err),  32'(m_err));
        check("busy", 32'(busy), 32'(m_phase != 0 || m_q.size() > 0));
`ifdef SCHED_EXEC_ERR_CNT_EN
        check("err_count", 32'(err_count), 32'(m_errcnt));
`endif
        if (sched_done) seg_done++;
        if (sched_err) seg_err++;
        if (mem_cmd_valid && first_valid_edge < 0) first_valid_edge = edge_n;
    endtask

    task automatic tick();
        if (mem_cmd_valid && mem_cmd_ready && !rst) obs.push_back(int'(mem_bank));
        @(posedge clk);
        model_edge();
        edge_n++;
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic seg_start();
        obs.delete();
        seg_done = 0;
        seg_err = 0;
        first_valid_edge = -1;
    endtask

    task automatic check_banks(input string tag);
        check({tag, "_ncmd"}, 32'(obs.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check(tag, (i < obs.size()) ? 32'(obs[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    endtask

    task automatic do_reset();
        rst = 1'b1; tx = 1'b0; mem_cmd_ready = 1'b0;
        run(2);
        check("rst_valid", 32'(mem_cmd_valid), 32'd0);
        check("rst_bank",  32'(mem_bank), 32'd0);
        check("rst_op",    32'(mem_op), 32'd0);
        check("rst_row",   32'(mem_row), 32'd0);
        check("rst_done",  32'(sched_done), 32'd0);
        check("rst_err",   32'(sched_err), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [3:0]  op;
        case ($urandom_range(0, 4))
            0: op = 4'h3;
            1: op = 4'h5;
            2, 3: op = 4'hA;
            default: op = 4'($urandom);
        endcase
        w = {8'h00, 8'($urandom), op, 4'h0, 8'($urandom)};
        if ($urandom_range(0, 9) == 0) w[31:24] = 8'($urandom_range(1, 255));
        if ($urandom_range(0, 9) == 0) w[11:8] = 4'($urandom_range(1, 15));
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        edge_n = 0;
        seg_start();

        // Held word captured once, full command burst
        do_reset();
        seg_start();
        mem_cmd_ready = 1'b1;
        schedule_in = 32'h00FBA020;
        cap_edge = edge_n + 1;
        tx = 1'b1;
        run(10);
        tx = 1'b0;
        run(10);
        exp_q = '{0, 1, 3, 4, 5, 6, 7};
        check_banks("t1_banks");
        check("t1_done", 32'(seg_done), 32'd1);
        check("t1_latency", 32'(first_valid_edge - cap_edge), 32'd2);

        // Word changes under a continuously high tx
        do_reset();
        seg_start();
        mem_cmd_ready = 1'b1;
        tx = 1'b1;
        schedule_in = 32'h00FBA020; run(3);
        schedule_in = 32'h003FA020; run(3);
        schedule_in = 32'h003BA020; run(3);
        tx = 1'b0;
        run(40);
        exp_q = '{0, 1, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 0, 1, 3, 4, 5};
        check_banks("t2_banks");
        check("t2_done", 32'(seg_done), 32'd3);

        // Malformed words are rejected
        do_reset();
        seg_start();
        mem_cmd_ready = 1'b1;
        tx = 1'b1; schedule_in = 32'h01FBA020; run(1);
        tx = 1'b0; run(1);
        tx = 1'b1; schedule_in = 32'h00FB7020; run(1);
        tx = 1'b0; run(10);
        check("t3_ncmd", 32'(obs.size()), 32'd0);
        check("t3_err", 32'(seg_err), 32'd2);
        check("t3_done", 32'(seg_done), 32'd0);
`ifdef SCHED_EXEC_ERR_CNT_EN
        check("t3_err_count", 32'(err_count), 32'd2);
`endif

        // Back-pressure mid-word
        do_reset();
        seg_start();
        mem_cmd_ready = 1'b1;
        tx = 1'b1; schedule_in = 32'h00FFA055; run(1);
        tx = 1'b0;
        for (int k = 0; k < 20 && obs.size() < 2; k++) tick();
        check("t4_reach", 32'(obs.size() >= 2), 32'd1);
        mem_cmd_ready = 1'b0;
        run(5);
        check("t4_stall_valid", 32'(mem_cmd_valid), 32'd1);
        mem_cmd_ready = 1'b1;
        run(15);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_banks("t4_banks");
        check("t4_done", 32'(seg_done), 32'd1);

        // FIFO overflow while a word is stalled
        do_reset();
        seg_start();
        tx = 1'b1; schedule_in = 32'h00FFA020; run(1);
        tx = 1'b0;
        for (int k = 0; k < 10 && !mem_cmd_valid; k++) tick();
        check("t5_stalled", 32'(mem_cmd_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tx = 1'b1;
            schedule_in = 32'h00005000 | (32'd1 << (16 + i)) | 32'(i);
            tick();
        end
        tx = 1'b0;
        run(3);
        check("t5_err", 32'(seg_err), 32'd2);
        mem_cmd_ready = 1'b1;
        run(40);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3};
        check_banks("t5_banks");
        check("t5_done", 32'(seg_done), 32'd5);

        // Reset abandons an in-flight word
        do_reset();
        seg_start();
        mem_cmd_ready = 1'b1;
        tx = 1'b1; schedule_in = 32'h00FFA020; run(1);
        tx = 1'b0;
        for (int k = 0; k < 20 && obs.size() < 3; k++) tick();
        check("t6_reach", 32'(obs.size() >= 3), 32'd1);
        rst = 1'b1; mem_cmd_ready = 1'b0;
        tick();
        check("t6_valid", 32'(mem_cmd_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        rst = 1'b0; mem_cmd_ready = 1'b1;
        seg_start();
        run(15);
        check("t6_ncmd", 32'(obs.size()), 32'd0);
        check("t6_done", 32'(seg_done), 32'd0);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) tx = ~tx;
            if ($urandom_range(0, 4) == 0) schedule_in = rand_word();
            mem_cmd_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0; tx = 1'b0; mem_cmd_ready = 1'b1;
        run(60);
        check("drain_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/schedule_executor.md
# schedule_executor

Receiving end of the memory-controller schedule link. Samples the 32-bit schedule word and `tx` strobe driven by the schedule selector and buffers valid words in a small FIFO. Each word is then expanded into one memory command per enabled bank, issued over a valid/ready interface to the memory command port. Malformed words are rejected and counted.

## Interface
- `FIFO_DEPTH`, default 4, number of buffered schedule words; must be a power of 2, minimum 2.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `tx`  in  1  schedule-valid level from the selector; may stay high for many cycles.
- `schedule_in`  in  32  schedule word; stable whenever `tx`=1 at a rising edge.
- `mem_cmd_valid`  out  1  command present.
- `mem_cmd_ready`  in  1  memory port accepts the command.
- `mem_bank`  out  3  target bank index.
- `mem_op`  out  4  opcode copied from the word.
- `mem_row`  out  8  row address copied from the word.
- `sched_done`  out  1  one-cycle pulse after the last command of a word is accepted.
- `sched_err`  out  1  one-cycle pulse when a word is rejected (malformed or FIFO full).
- `busy`  out  1  high when the FSM is not idle or the FIFO is non-empty.

## Operation
- Word fields:
  - [31:24] reserved, must be 0.
  - [23:16] bank mask; bit i enables bank i.
  - [15:12] opcode; valid values are 0x3 (refresh), 0x5 (write) and 0xA (read).
  - [11:8] reserved, must be 0.
  - [7:0] base row.
- Capture rule: a word is captured at an edge where `tx`=1 and either the registered previous `tx`=0, or `schedule_in` ≠ the last captured word. While `tx` stays high, a held word is therefore captured only once.
- Captured word is malformed if any reserved bit is set or the opcode is not in the valid set. A malformed word is dropped and `sched_err` pulses.
- Captured well-formed word with the FIFO full: the word is dropped and `sched_err` pulses. A pop in the same cycle does not rescue the push.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop into the working registers and go to ISSUE.
  - ISSUE: present the lowest set bit of the remaining mask as `mem_bank`. On `mem_cmd_valid && mem_cmd_ready`, clear that bit. When the mask becomes 0, go to DONE.
  - DONE: pulse `sched_done`, return to IDLE.
- A word with mask 0 goes IDLE→ISSUE→DONE with no command issued.
- `mem_op`/`mem_row` are constant for all commands of one word. `mem_bank`/`mem_op`/`mem_row` are held stable while `mem_cmd_valid`=1 and `mem_cmd_ready`=0.
- Reset mid-operation: FIFO emptied, working registers cleared, FSM to IDLE; any in-flight command is abandoned.

## Timing
- Reset values:
  - `mem_cmd_valid`=0, `mem_bank`=0, `mem_op`=0, `mem_row`=0.
  - `sched_done`=0, `sched_err`=0, `busy`=0.
  - Previous-`tx` register=0, last-captured word=0.
- Capture at edge C: word written to the FIFO at C. `sched_err` (if any) is high in cycle C+1.
- With the FIFO empty and the FSM idle, the pop happens at edge C+1 and `mem_cmd_valid` rises after edge C+2.
- Successive commands of one word issue back-to-back, one per cycle, while `mem_cmd_ready`=1.
- `sched_done` is high for the single cycle after the last handshake. IDLE may pop the next word one cycle after DONE.
- Capture and pop may occur in the same cycle whenever the FIFO is not full.

## Configuration
- `SCHED_EXEC_ERR_CNT_EN` defined: adds output `err_count` (8 bits). It increments on every `sched_err` pulse, saturates at 255, and resets to 0.
- Macro undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `sched_pkg`:
  - Opcode constants OP_REFRESH=4'h3, OP_WRITE=4'h5, OP_READ=4'hA.
  - Field bit positions.
  - FSM state enum (IDLE, ISSUE, DONE).
  - Validity function for a schedule word.
- Sub-module `sched_fifo`: synchronous FIFO, width 32, depth `FIFO_DEPTH`, with full/empty flags. Write is ignored when full; read is ignored when empty.
- Top level holds the capture logic, the FSM and the bank priority encoder.

## Test plan
- `tx` held high 10 cycles with 0x00FBA020, `mem_cmd_ready`=1:
  - Exactly one capture.
  - 7 commands, banks 0,1,3,4,5,6,7, op 0xA, row 0x20.
  - First valid 2 cycles after capture; `sched_done` once.
- `tx` high while the word changes 0x00FBA020 → 0x003FA020 → 0x003BA020:
  - Three words executed in order.
  - Banks of the 2nd word: 0–5. Banks of the 3rd word: 0,1,3,4,5.
- Malformed words 0x01FBA020 and 0x00FB7020:
  - No commands issued; `sched_err` pulses twice.
  - `err_count`=2 with the macro defined.
- `mem_cmd_ready` held low 5 cycles mid-word: `mem_cmd_valid` and fields stay stable, with no bank skipped or repeated.
- Six distinct words captured back-to-back with `mem_cmd_ready`=0:
  - 4 buffered and 2 rejected with `sched_err`.
  - After ready=1, exactly 4 words execute.
- `rst` asserted during ISSUE of 0x00FFA020: the next cycle has `mem_cmd_valid`=0 and `busy`=0, and no commands follow.
